// File: rtl/mix_tree_sequencer.sv
// mix_tree_sequencer: fill/mix/transfer sequencing for a 2^LEVELS-inlet binary mixing tree
module mix_tree_sequencer #(
  parameter int LEVELS = 3,
  parameter int FILL_CYCLES = 16,
  parameter int CNT_W = 16,
  localparam int NODES = (1 << LEVELS) - 1,
  localparam int LW = $clog2(LEVELS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] mix_cycles,
  input  logic             hold,
  input  logic             abort,
  output logic [NODES-1:0] fill_en,
  output logic [NODES-1:0] mix_en,
  output logic [NODES-1:0] xfer_en,
  output logic [LW-1:0]    level,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  typedef enum logic [1:0] {IDLE, FILL, MIX, XFER} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, mix_q;
  logic done_d, aborted_d, frz;
  // heap-order mixers of level l have indices whose (index+1) has bit-length l+1
  function automatic logic [NODES-1:0] level_mask(input logic [LW-1:0] l);
    logic [NODES-1:0] m;
    m = '0;
    for (int i = 0; i < NODES; i++) m[i] = ((i + 1) >> l) == 1;
    return m;
  endfunction
  // state, level, phase counter and latched mix duration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q <= '0;
      cnt_q <= '0;
      mix_q <= '0;
    end else begin
      state_q <= state_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && start) mix_q <= (mix_cycles == '0) ? CNT_W'(1) : mix_cycles;
    end
  end
  // next state: abort wins, hold freezes, otherwise count the phase down to 1
  always_comb begin
    state_d = state_q;
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    aborted_d = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      lvl_d = '0;
      aborted_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = FILL;
        lvl_d = LW'(LEVELS - 1);
        cnt_d = CNT_W'(FILL_CYCLES);
      end
    end else if (!hold) begin
      if (cnt_q > CNT_W'(1)) cnt_d = cnt_q - 1'b1;
      else if (state_q == FILL || (state_q == XFER && lvl_q != '0)) begin
        state_d = MIX;
        lvl_d = (state_q == XFER) ? lvl_q - 1'b1 : lvl_q;
        cnt_d = (mix_q == '0) ? CNT_W'(1) : mix_q;
      end else if (state_q == MIX) begin
        state_d = XFER;
        cnt_d = CNT_W'(FILL_CYCLES);
      end else begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  assign frz = hold && state_q != IDLE;
  // outputs registered from the next state so they line up with the phase they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_en <= '0;
      mix_en <= '0;
      xfer_en <= '0;
      level <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      fill_en <= (state_d == FILL && !frz) ? level_mask(lvl_d) : '0;
      mix_en <= (state_d == MIX && !frz) ? level_mask(lvl_d) : '0;
      xfer_en <= (state_d == XFER && !frz) ? level_mask(lvl_d) : '0;
      level <= (state_d == IDLE) ? '0 : lvl_d;
      busy <= state_d != IDLE;
      done <= done_d;
      aborted <= aborted_d;
    end
  end
endmodule

// File: tb/tb_mix_tree_sequencer.sv
// tb_mix_tree_sequencer: scoreboard and vector checks for the mixing-tree sequencer
module tb_mix_tree_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, hold, abort;
  logic [15:0] mix_cycles;
  logic [6:0] fill_en, mix_en, xfer_en;
  logic [1:0] level;
  logic busy, done, aborted;
  logic rst1_n, start1, hold1, abort1;
  logic [15:0] mix1;
  logic [0:0] fill1, mixe1, xfer1, level1;
  logic busy1, done1, aborted1;
  int n_chk = 0, n_fail = 0;
  logic [25:0] sb[$];
  logic [6:0] lmask [3] = '{7'h01, 7'h06, 7'h78};
  typedef struct {int m; int len;} vec_t;
  vec_t vecs [4];
  int bn;

  always #5 clk = ~clk;

  mix_tree_sequencer #(.LEVELS(3), .FILL_CYCLES(16), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mix_cycles(mix_cycles), .hold(hold), .abort(abort),
    .fill_en(fill_en), .mix_en(mix_en), .xfer_en(xfer_en), .level(level),
    .busy(busy), .done(done), .aborted(aborted));

  mix_tree_sequencer #(.LEVELS(1), .FILL_CYCLES(16), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .mix_cycles(mix1), .hold(hold1), .abort(abort1),
    .fill_en(fill1), .mix_en(mixe1), .xfer_en(xfer1), .level(level1),
    .busy(busy1), .done(done1), .aborted(aborted1));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [25:0] pk(input logic [6:0] f, input logic [6:0] m, input logic [6:0] x,
                                     input logic [1:0] lv, input logic b, input logic d, input logic a);
    return {f, m, x, lv, b, d, a};
  endfunction

  task automatic push_run(input int m_in, input bit tail);
    int m;
    m = (m_in == 0) ? 1 : m_in;
    repeat (16) sb.push_back(pk(lmask[2], 0, 0, 2, 1, 0, 0));
    for (int lv = 2; lv >= 0; lv--) begin
      repeat (m) sb.push_back(pk(0, lmask[lv], 0, 2'(lv), 1, 0, 0));
      repeat (16) sb.push_back(pk(0, 0, lmask[lv], 2'(lv), 1, 0, 0));
    end
    sb.push_back(pk(0, 0, 0, 0, 0, 1, 0));
    if (tail) sb.push_back(pk(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic drive(input int m, input int hold_at, input int hold_len, input int abort_at,
                       input int st_a, input int st_b, input int m_b, output int busy_n);
    int c;
    busy_n = 0;
    mix_cycles = 16'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      chk($sformatf("u0 outputs cycle %0d", c), 32'({fill_en, mix_en, xfer_en, level, busy, done, aborted}),
          32'(sb.pop_front()));
      busy_n += int'(busy);
      hold = (c >= hold_at && c < hold_at + hold_len);
      abort = (c == abort_at);
      start = (c == st_a || c == st_b);
      if (c == st_a) mix_cycles = 16'd7;
      if (c == st_b) mix_cycles = 16'(m_b);
      @(posedge clk); #1;
      c++;
    end
    hold = 1'b0;
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4, 76};
    vecs[1] = '{0, 67};
    vecs[2] = '{1, 67};
    vecs[3] = '{9, 91};
    rst_n = 1'b0; rst1_n = 1'b0;
    start = 1'b0; hold = 1'b0; abort = 1'b0; mix_cycles = 16'd0;
    start1 = 1'b0; hold1 = 1'b0; abort1 = 1'b0; mix1 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset u0", 32'({fill_en, mix_en, xfer_en, level, busy, done, aborted}), 0);
    chk("reset u1", 32'({fill1, mixe1, xfer1, level1, busy1, done1, aborted1}), 0);
    rst_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;
    hold = 1'b1; abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold/abort busy", 32'(busy), 0);
    chk("idle abort pulse", 32'(aborted), 0);
    hold = 1'b0; abort = 1'b0;
    foreach (vecs[i]) begin
      push_run(vecs[i].m, 1);
      drive(vecs[i].m, -1, 0, -1, -1, -1, 0, bn);
      chk($sformatf("busy length mix=%0d", vecs[i].m), 32'(bn), 32'(vecs[i].len));
    end
    push_run(4, 1);
    repeat (5) sb.insert(37, pk(0, 0, 0, 1, 1, 0, 0));
    drive(4, 37, 5, -1, -1, -1, 0, bn);
    chk("busy length with hold", 32'(bn), 81);
    push_run(4, 1);
    while (sb.size() > 23) void'(sb.pop_back());
    repeat (2) sb.push_back(pk(0, 0, 0, 2, 1, 0, 0));
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 1));
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    drive(4, 23, 3, 25, -1, -1, 0, bn);
    chk("busy length aborted", 32'(bn), 25);
    push_run(2, 0);
    push_run(0, 1);
    drive(2, -1, 0, -1, 10, 71, 0, bn);
    chk("busy length back-to-back", 32'(bn), 137);
    mix1 = 16'd3;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("u1 mixing before reset", 32'({fill1, mixe1, xfer1, busy1}), 32'b0101);
    rst1_n = 1'b0;
    #1;
    chk("u1 async reset", 32'({fill1, mixe1, xfer1, level1, busy1, done1, aborted1}), 0);
    @(posedge clk); #1;
    rst1_n = 1'b1;
    @(posedge clk); #1;
    chk("u1 after reset no pulse", 32'({fill1, mixe1, xfer1, level1, busy1, done1, aborted1}), 0);
    mix1 = 16'd5;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    bn = 0;
    for (int c = 1; c <= 39; c++) begin
      chk($sformatf("u1 outputs cycle %0d", c), 32'({fill1, mixe1, xfer1, level1, busy1, done1, aborted1}),
          32'({c <= 16, c >= 17 && c <= 21, c >= 22 && c <= 37, 1'b0, c <= 37, c == 38, 1'b0}));
      bn += int'(busy1);
      @(posedge clk); #1;
    end
    chk("u1 busy length", 32'(bn), 37);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mix_tree_sequencer.md
# mix_tree_sequencer

Sequencer for a parametrised binary mixing tree of 2^LEVELS reagent inlets and 2^LEVELS-1 two-input mixers. It generalises the fixed 8-inlet PCR tree to any depth and adds run-time control. Per start it fills the leaf mixers, then mixes and transfers level by level up to the root, driving per-mixer valve and pump enables. It sits between the host control FSM and the valve/pump drivers of the flow layer.

## Interface
- LEVELS, 3, tree depth; mixers NODES = 2^LEVELS-1, inlets 2^LEVELS (3 = 8-inlet PCR tree)
- FILL_CYCLES, 16, cycles a fill or transfer phase lasts (≥1)
- CNT_W, 16, width of mix-time input and phase counter
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled in IDLE only
- mix_cycles  in  CNT_W  mix duration per level; latched at start, 0 treated as 1
- hold  in  1  pause: freeze counter and phase, outputs forced low while high
- abort  in  1  terminate run, return to IDLE
- fill_en  out  NODES  leaf inlet valves open (leaf mixers only ever set)
- mix_en  out  NODES  peristaltic mix pump on, per mixer
- xfer_en  out  NODES  mixer outlet valve open (into parent, or result port for root)
- level  out  $clog2(LEVELS+1)  level being processed (0 = root)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, run completed normally
- aborted  out  1  one-cycle pulse, run terminated by abort

## Operation
- Mixers indexed in heap order: root 0, children of i are 2i+1 and 2i+2; level L holds indices 2^L-1 .. 2^(L+1)-2.
- States: IDLE, FILL, MIX, XFER.
- IDLE & start: latch mix_cycles (0→1), level←LEVELS-1, go FILL.
- FILL: fill_en set for all level-(LEVELS-1) mixers, FILL_CYCLES cycles → MIX.
- MIX: mix_en set for all mixers at current level, latched mix-cycles count → XFER.
- XFER: xfer_en set for all mixers at current level, FILL_CYCLES cycles. Then if level = 0 → IDLE with done; else level←level-1, → MIX.
- Bits for mixers outside the active level are always 0; at most one of fill_en/mix_en/xfer_en groups nonzero.
- hold (non-IDLE): phase counter and state frozen; all enables 0; busy stays 1. On release, phase resumes with remaining count.
- abort (non-IDLE): next cycle IDLE, all enables 0, aborted=1, done=0. abort beats hold. abort in IDLE ignored.
- start outside IDLE ignored; mix_cycles changes mid-run ignored.
- LEVELS=1: FILL, MIX, XFER on mixer 0 only.

## Timing
- All outputs registered, decoded from next state; reset values: enables 0, level 0, busy 0, done 0, aborted 0, state IDLE.
- start high at edge t → busy and first enable high from cycle t+1.
- Unheld run length: FILL_CYCLES + LEVELS·(M + FILL_CYCLES) busy cycles, M = latched mix count.
- done/aborted asserted in the first IDLE cycle, one cycle only; start in that same cycle is accepted (busy again next cycle).
- Each held cycle extends the run by one cycle; hold in IDLE has no effect.
- rst_n low at any time: immediate return to reset values, no done/aborted pulse.
- Phase counter CNT_W bits, counts down to 1; no wrap for any legal input.

## Test plan
- LEVELS=3, FILL_CYCLES=16, mix_cycles=4, start at cycle 0 -> fill_en=0x78 cycles 1-16; mix_en 0x78 17-20; xfer_en 0x78 21-36; mix_en 0x06 37-40; xfer_en 0x06 41-56; mix_en 0x01 57-60; xfer_en 0x01 61-76; done=1 cycle 77 only.
- mix_cycles=0 -> each MIX phase lasts exactly 1 cycle; run 16+3·17=67 busy cycles.
- hold high 5 cycles mid-MIX at level 1 -> enables 0 during hold, level=1, busy=1; done 5 cycles later than unheld run.
- abort during XFER level 2 (with hold also high) -> next cycle IDLE, enables 0, aborted=1 one cycle, done never asserted.
- start repeated while busy, and start in done cycle -> mid-run start has no effect; done-cycle start begins a new run with busy at next cycle.
- rst_n low during MIX, LEVELS=1 build -> outputs zero asynchronously; after release, a run yields fill/mix/xfer on bit 0 only, 16+mix+16 busy cycles.
